univ_counter_mod: RTL and testbench
===================================

UNIV_COUNTER_MOD -- requirements
Module: univ_counter_mod

Interface
REQ-001 SHALL have parameter N, default 8, counter width in bits (N >= 2).
REQ-002 SHALL have parameter M, default 256, count modulus; legal range 2..2**N.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port clr, input, 1, synchronous clear of the count to 0.
REQ-006 SHALL have port load, input, 1, parallel load of d.
REQ-007 SHALL have port en, input, 1, count enable.
REQ-008 SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-009 SHALL have port d, input, N, parallel load value.
REQ-010 SHALL have port q, output, N, current count (register output, no combinational path from inputs).
REQ-011 SHALL have port max_tick, output, 1, combinational flag, high when q == M-1.
REQ-012 SHALL have port min_tick, output, 1, combinational flag, high when q == 0.
REQ-013 SHALL have port wrap, output, 1, registered one-cycle pulse marking a modulus wrap.

Function
REQ-014 SHALL apply per-edge priority: reset > clr > load > en > hold.
REQ-015 SHALL, on clr, set q=0 and wrap=0.
REQ-016 SHALL, on load, set q=d if d < M, else q=M-1 (clamp); wrap=0.
REQ-017 SHALL, on en with up=1, set q=q+1 if q < M-1, else q=0 and wrap=1 next cycle.
REQ-018 SHALL, on en with up=0, set q=q-1 if q > 0, else q=M-1 and wrap=1 next cycle.
REQ-019 SHALL, with en=0 and no clr/load, hold q and drive wrap=0.
REQ-020 SHALL hold wrap high for exactly the one cycle following the wrapping edge; consecutive wraps (M=2 case) give consecutive pulses.
REQ-021 SHALL compute next count in N+1 bits internally so no intermediate overflow occurs when M = 2**N.
REQ-022 SHALL allow up to change on any cycle; direction takes effect on the same edge.
REQ-023 SHALL, when q is outside 0..M-1 (unreachable but defensive), treat next enabled count as 0 for up=1 and M-1 for up=0.

Reset
REQ-024 SHALL, on reset high at a clk edge, set q=0 and wrap=0, regardless of clr/load/en.
REQ-025 SHALL give reset-state outputs q=0, min_tick=1, max_tick=0 (M>1), wrap=0.
REQ-026 SHALL, on reset mid-count, discard any pending wrap; the next cycle after reset deasserts counts from 0.

Configuration
REQ-027 SHALL, with macro UNIV_COUNTER_SAT_EN defined, saturate: up=1 at q=M-1 holds M-1, up=0 at q=0 holds 0, and wrap is never asserted.
REQ-028 SHALL, with UNIV_COUNTER_SAT_EN undefined, wrap per REQ-017/018; port list identical in both builds.

Verification (N=4, M=10 unless stated)
REQ-029 SHALL cover: reset, en=1, up=1 for 12 cycles -> q 0..9,0,1; max_tick high at q=9; wrap high one cycle after 9->0.
REQ-030 SHALL cover: load d=3, en=1, up=0 for 5 cycles -> q 3,2,1,0,9,8; min_tick at q=0; wrap pulse after 0->9.
REQ-031 SHALL cover: load d=14 -> q=9 (clamp); simultaneous clr=1, load=1, en=1 -> q=0.
REQ-032 SHALL cover: q=7, assert reset with load=1, d=5 -> q=0, wrap=0; with N=4, M=16 count 15->0 gives wrap.
REQ-033 SHALL cover: UNIV_COUNTER_SAT_EN defined, up=1 from q=8 for 4 cycles -> q 9,9,9,9, wrap stays 0; up=0 from 1 -> 0,0.
REQ-034 SHALL cover: en toggled 1,0,1 at q=9 with up=1 -> q 0,0,1; single wrap pulse only.

Source files
------------

// File: rtl/univ_counter_mod.sv
// univ_counter_mod: modulus-M up/down counter with clear, clamped load and wrap pulse
// Ports: clk, reset (sync, active high), clr, load, en, up, d[N-1:0] in;
//        q[N-1:0] registered count, max_tick (q==M-1), min_tick (q==0), wrap (registered pulse).
// Build option: define UNIV_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module univ_counter_mod #(
  parameter int N = 8,
  parameter int M = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap
);
  localparam logic [N:0] last = (N+1)'(M - 1);
`ifdef UNIV_COUNTER_SAT_EN
  localparam logic sat = 1'b1;
`else
  localparam logic sat = 1'b0;
`endif
  // Count kept one bit wider so M = 2**N never overflows; bit N also feeds the range check.
  logic [N:0] q_r, q_next, dx;
  logic wrap_next, at_top, at_bot, in_range;
  always_comb begin
    dx = {1'b0, d};
    in_range = q_r <= last;
    at_top = q_r == last;
    at_bot = q_r == '0;
    q_next = q_r;
    wrap_next = 1'b0;
    if (clr) q_next = '0;
    else if (load) q_next = dx > last ? last : dx;
    else if (en) begin
      if (!in_range) q_next = up ? '0 : last;
      else if (up) begin
        q_next = at_top ? (sat ? last : '0) : q_r + 1'b1;
        wrap_next = at_top & ~sat;
      end else begin
        q_next = at_bot ? (sat ? '0 : last) : q_r - 1'b1;
        wrap_next = at_bot & ~sat;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
      wrap <= 1'b0;
    end else begin
      q_r <= q_next;
      wrap <= wrap_next;
    end
  end
  assign q = q_r[N-1:0];
  assign max_tick = at_top;
  assign min_tick = at_bot;
endmodule

// File: tb/tb_univ_counter_mod.sv
// tb_univ_counter_mod: directed self-checking bench for univ_counter_mod (N=4, M=10 and M=16)
module tb_univ_counter_mod;
  logic clk = 1'b0;
  logic reset, clr, load, en, up;
  logic [3:0] d, q, q2;
  logic max_tick, min_tick, wrap, max2, min2, wrap2;
  int checks = 0;
  int failures = 0;

  univ_counter_mod #(.N(4), .M(10)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .en(en), .up(up), .d(d),
    .q(q), .max_tick(max_tick), .min_tick(min_tick), .wrap(wrap)
  );
  univ_counter_mod #(.N(4), .M(16)) dut16 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .en(en), .up(up), .d(d),
    .q(q2), .max_tick(max2), .min_tick(min2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, c, l, e, u, input logic [3:0] dv);
    reset = r; clr = c; load = l; en = e; up = u; d = dv;
  endtask

  task automatic test_reset;
    drive(1, 1, 1, 1, 1, 4'd7);
    step;
    checks++; if (q !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++; if (min_tick !== 1'b1) begin failures++; $display("FAIL reset_min got=%b exp=1", min_tick); end
    checks++; if (max_tick !== 1'b0) begin failures++; $display("FAIL reset_max got=%b exp=0", max_tick); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_count_up;
    int exp_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    drive(1, 0, 0, 0, 1, 4'd0);
    step;
    drive(0, 0, 0, 1, 1, 4'd0);
    for (int i = 0; i < 12; i++) begin
      step;
      checks++; if (q !== exp_q[i][3:0]) begin failures++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, q, exp_q[i]); end
      checks++; if (wrap !== (i == 9)) begin failures++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap, i == 9); end
      checks++; if (max_tick !== (i == 8)) begin failures++; $display("FAIL up_max[%0d] got=%b exp=%b", i, max_tick, i == 8); end
    end
  endtask

  task automatic test_count_down;
    int exp_q[5] = '{2, 1, 0, 9, 8};
    drive(0, 0, 1, 0, 0, 4'd3);
    step;
    checks++; if (q !== 4'd3) begin failures++; $display("FAIL down_load got=%0d exp=3", q); end
    drive(0, 0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step;
      checks++; if (q !== exp_q[i][3:0]) begin failures++; $display("FAIL down_q[%0d] got=%0d exp=%0d", i, q, exp_q[i]); end
      checks++; if (wrap !== (i == 3)) begin failures++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, wrap, i == 3); end
      checks++; if (min_tick !== (i == 2)) begin failures++; $display("FAIL down_min[%0d] got=%b exp=%b", i, min_tick, i == 2); end
    end
  endtask

  task automatic test_clamp_priority;
    drive(0, 0, 1, 0, 1, 4'd14);
    step;
    checks++; if (q !== 4'd9) begin failures++; $display("FAIL clamp got=%0d exp=9", q); end
    checks++; if (max_tick !== 1'b1) begin failures++; $display("FAIL clamp_max got=%b exp=1", max_tick); end
    drive(0, 1, 1, 1, 1, 4'd5);
    step;
    checks++; if (q !== 4'd0) begin failures++; $display("FAIL clr_prio got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL clr_wrap got=%b exp=0", wrap); end
    drive(0, 0, 1, 1, 1, 4'd5);
    step;
    checks++; if (q !== 4'd5) begin failures++; $display("FAIL load_prio got=%0d exp=5", q); end
    drive(0, 0, 0, 0, 1, 4'd0);
    step;
    checks++; if (q !== 4'd5) begin failures++; $display("FAIL hold got=%0d exp=5", q); end
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 1, 0, 1, 4'd7);
    step;
    drive(1, 0, 1, 1, 1, 4'd5);
    step;
    checks++; if (q !== 4'd0) begin failures++; $display("FAIL rst_mid_q got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rst_mid_wrap got=%b exp=0", wrap); end
    drive(0, 0, 1, 0, 1, 4'd9);
    step;
    drive(1, 0, 0, 1, 1, 4'd0);
    step;
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rst_pending_wrap got=%b exp=0", wrap); end
    drive(0, 0, 0, 1, 1, 4'd0);
    step;
    checks++; if (q !== 4'd1) begin failures++; $display("FAIL rst_resume got=%0d exp=1", q); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL rst_resume_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_direction;
    drive(0, 0, 1, 0, 1, 4'd5);
    step;
    drive(0, 0, 0, 1, 1, 4'd0);
    step;
    checks++; if (q !== 4'd6) begin failures++; $display("FAIL dir_up got=%0d exp=6", q); end
    up = 1'b0;
    step;
    checks++; if (q !== 4'd5) begin failures++; $display("FAIL dir_down got=%0d exp=5", q); end
  endtask

  task automatic test_en_toggle;
    drive(0, 0, 1, 0, 1, 4'd9);
    step;
    drive(0, 0, 0, 1, 1, 4'd0);
    step;
    checks++; if (q !== 4'd0 || wrap !== 1'b1) begin failures++; $display("FAIL tog0 got q=%0d w=%b exp q=0 w=1", q, wrap); end
    en = 1'b0;
    step;
    checks++; if (q !== 4'd0 || wrap !== 1'b0) begin failures++; $display("FAIL tog1 got q=%0d w=%b exp q=0 w=0", q, wrap); end
    en = 1'b1;
    step;
    checks++; if (q !== 4'd1 || wrap !== 1'b0) begin failures++; $display("FAIL tog2 got q=%0d w=%b exp q=1 w=0", q, wrap); end
  endtask

  task automatic test_m16;
    drive(1, 0, 0, 0, 1, 4'd0);
    step;
    drive(0, 0, 0, 1, 1, 4'd0);
    repeat (15) step;
    checks++; if (q2 !== 4'd15 || max2 !== 1'b1) begin failures++; $display("FAIL m16_top got q=%0d max=%b exp q=15 max=1", q2, max2); end
    step;
    checks++; if (q2 !== 4'd0 || wrap2 !== 1'b1) begin failures++; $display("FAIL m16_wrap got q=%0d w=%b exp q=0 w=1", q2, wrap2); end
    step;
    checks++; if (q2 !== 4'd1 || wrap2 !== 1'b0) begin failures++; $display("FAIL m16_after got q=%0d w=%b exp q=1 w=0", q2, wrap2); end
  endtask

  task automatic test_saturate;
    drive(0, 0, 1, 0, 1, 4'd8);
    step;
    drive(0, 0, 0, 1, 1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step;
      checks++; if (q !== 4'd9 || wrap !== 1'b0) begin failures++; $display("FAIL sat_up[%0d] got q=%0d w=%b exp q=9 w=0", i, q, wrap); end
    end
    drive(0, 0, 1, 0, 0, 4'd1);
    step;
    drive(0, 0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      step;
      checks++; if (q !== 4'd0 || wrap !== 1'b0) begin failures++; $display("FAIL sat_down[%0d] got q=%0d w=%b exp q=0 w=0", i, q, wrap); end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 1, 4'd0);
    test_reset;
    test_clamp_priority;
    test_reset_mid;
    test_direction;
`ifdef UNIV_COUNTER_SAT_EN
    test_saturate;
`else
    test_count_up;
    test_count_down;
    test_en_toggle;
    test_m16;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
